seg7_capture_decoder: RTL and testbench
=======================================

SEG7_CAPTURE_DECODER -- requirements
Module: seg7_capture_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive identical synchronized samples required before a digit is captured (legal 2..15).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port segments_in  input  7  asynchronous segment lines; bit 0 top, 1 upper-right, 2 lower-right, 3 bottom, 4 lower-left, 5 upper-left, 6 middle.
REQ-005 SHALL have port digit_sel_in  input  4  asynchronous digit-common lines of a 4-digit multiplexed display, active-high one-hot, bit n = digit n.
REQ-006 SHALL have port invert  input  1  1 = segments active-low (common anode), 0 = segments active-high (common cathode); quasi-static.
REQ-007 SHALL have port frame_out  output  16  last completed frame, digit n in bits [4n+3:4n].
REQ-008 SHALL have port frame_err  output  4  per-digit flag, 1 = that digit's pattern in frame_out was not a legal glyph.
REQ-009 SHALL have port frame_ready  output  1  frame_out holds an unacknowledged complete frame.
REQ-010 SHALL have port frame_ack  input  1  consumer acknowledge, sampled only while frame_ready = 1.
REQ-011 SHALL have port overrun  output  1  sticky; a further complete frame was seen while frame_ready = 1.

Function
REQ-012 SHALL pass segments_in and digit_sel_in through a 2-flop synchronizer before any other use.
REQ-013 SHALL form lit[6:0] = invert ? ~sync_segments : sync_segments.
REQ-014 SHALL decode lit (bits 6..0) as: 0111111=0, 0000110=1, 1011011=2, 1001111=3, 1100110=4, 1101101=5, 1111101=6, 0000111=7, 1111111=8, 1101111=9, 1110111=A, 1111100=b, 0111001=C, 1011110=d, 1111001=E, 1110001=F; any other pattern decodes to nibble 0 with error = 1.
REQ-015 SHALL keep a 4-bit stability counter: cleared when the synchronized {sel, segments} differs from the previous cycle's value or sel is not exactly one-hot; otherwise incremented, saturating at STABLE_CYCLES.
REQ-016 SHALL capture exactly once per stable period, on the edge where the counter goes from STABLE_CYCLES-1 to STABLE_CYCLES: write decoded nibble and error into the live slot of the selected digit and set that digit's bit in a 4-bit capture mask.
REQ-017 SHALL thereby capture a value held steady on the pins STABLE_CYCLES+2 rising edges after it is first sampled; sel all-zero, multi-hot or changing within that window SHALL produce no capture.
REQ-018 SHALL implement a 2-state FSM: COLLECT (reset state) and READY.
REQ-019 In COLLECT, when the mask (including the current capture) equals 1111: load frame_out/frame_err from live slots (including the current capture), clear the mask, set frame_ready, go to READY, all on the same edge.
REQ-020 In READY, frame_out, frame_err and frame_ready SHALL hold; captures continue into live slots and mask.
REQ-021 In READY, mask reaching 1111 SHALL set overrun, clear mask, leave frame_out unchanged.
REQ-022 In READY with frame_ack = 1: clear frame_ready, clear overrun, clear mask, go to COLLECT; an overrun event on the same edge SHALL be dropped (ack wins).
REQ-023 frame_ack while in COLLECT SHALL be ignored.
REQ-024 A change of invert SHALL be treated as any input change only via REQ-015 effects on lit; no other side effects.

Reset
REQ-025 While reset_n = 0 at a rising edge: synchronizers, counter, mask, live slots cleared; frame_out = 0000, frame_err = 0000, frame_ready = 0, overrun = 0; FSM = COLLECT.
REQ-026 Reset asserted mid-frame or in READY SHALL discard all partial and unacknowledged data; first capture after release requires a full STABLE_CYCLES+2 window.

Verification
REQ-027 invert=1, digits 0..3 each held 10 cycles with segments_in = ~pattern of 1,2,3,4 -> frame_ready=1, frame_out=16'h4321, frame_err=0000.
REQ-028 invert=0, digit 2 shows 0000001 (illegal) among legal 8,8,8 -> frame_out=16'h8088, frame_err=0100.
REQ-029 Sel held 3 cycles only (STABLE_CYCLES=4), or sel=0101 -> no capture, frame_ready stays 0.
REQ-030 Two full frames without ack -> overrun=1, frame_out still first frame; frame_ack pulse -> frame_ready=0, overrun=0 next edge.
REQ-031 reset_n low for 1 cycle while in READY -> all outputs 0 next edge, FSM COLLECT.
REQ-032 Glitch: segments change once within the stable window -> counter restarts, single capture of final value only.

Source files
------------

// File: rtl/seg7_capture_decoder.sv
// Purpose: recovers 4-digit hex frames by snooping a multiplexed 7-segment display's pins.
// Latency: a digit is captured STABLE_CYCLES+2 edges after it first appears on the pins; the frame loads on the same edge as its last capture.
// Backpressure: frame_ready holds frame_out until frame_ack; complete frames seen while it is held are dropped and flagged on overrun.
module seg7_capture_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  segments_in,
    input  logic [3:0]  digit_sel_in,
    input  logic        invert,
    output logic [15:0] frame_out,
    output logic [3:0]  frame_err,
    output logic        frame_ready,
    input  logic        frame_ack,
    output logic        overrun
);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        READY   = 1'b1
    } state_t;

    localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);

    logic [6:0]  seg_meta, seg_sync;
    logic [3:0]  sel_meta, sel_sync;
    logic [6:0]  lit;
    logic [6:0]  prev_lit;
    logic [3:0]  prev_sel;
    logic [3:0]  stable_cnt;
    logic        sel_onehot;
    logic [1:0]  sel_idx;
    logic        same;
    logic        capture;
    logic [3:0]  dec_nib;
    logic        dec_err;
    logic [15:0] live_nib_q, live_nib_d;
    logic [3:0]  live_err_q, live_err_d;
    logic [3:0]  cap_bits;
    logic [3:0]  mask_q, mask_d;
    logic        mask_full;
    state_t      state_q, state_d;
    logic        load_frame;
    logic        set_overrun;
    logic        ack_take;

    // Pins are unrelated to clk, so nothing touches them before two flops.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            seg_meta <= '0;
            seg_sync <= '0;
            sel_meta <= '0;
            sel_sync <= '0;
        end else begin
            seg_meta <= segments_in;
            seg_sync <= seg_meta;
            sel_meta <= digit_sel_in;
            sel_sync <= sel_meta;
        end
    end

    assign lit = invert ? ~seg_sync : seg_sync;

    always_comb begin
        sel_onehot = 1'b1;
        sel_idx    = 2'd0;
        case (sel_sync)
            4'b0001: sel_idx = 2'd0;
            4'b0010: sel_idx = 2'd1;
            4'b0100: sel_idx = 2'd2;
            4'b1000: sel_idx = 2'd3;
            default: sel_onehot = 1'b0;
        endcase
    end

    // Stability is judged on lit so that flipping invert restarts the window too.
    assign same    = ({sel_sync, lit} == {prev_sel, prev_lit});
    assign capture = same && sel_onehot && (stable_cnt == STABLE_MAX - 4'd1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_sel   <= '0;
            prev_lit   <= '0;
            stable_cnt <= '0;
        end else begin
            prev_sel <= sel_sync;
            prev_lit <= lit;
            if (!same || !sel_onehot) begin
                stable_cnt <= '0;
            end else if (stable_cnt != STABLE_MAX) begin
                stable_cnt <= stable_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        dec_nib = 4'h0;
        dec_err = 1'b0;
        case (lit)
            7'b0111111: dec_nib = 4'h0;
            7'b0000110: dec_nib = 4'h1;
            7'b1011011: dec_nib = 4'h2;
            7'b1001111: dec_nib = 4'h3;
            7'b1100110: dec_nib = 4'h4;
            7'b1101101: dec_nib = 4'h5;
            7'b1111101: dec_nib = 4'h6;
            7'b0000111: dec_nib = 4'h7;
            7'b1111111: dec_nib = 4'h8;
            7'b1101111: dec_nib = 4'h9;
            7'b1110111: dec_nib = 4'hA;
            7'b1111100: dec_nib = 4'hB;
            7'b0111001: dec_nib = 4'hC;
            7'b1011110: dec_nib = 4'hD;
            7'b1111001: dec_nib = 4'hE;
            7'b1110001: dec_nib = 4'hF;
            default:    dec_err = 1'b1;
        endcase
    end

    // Live slots including this edge's capture, so a frame can load in the same cycle.
    always_comb begin
        live_nib_d = live_nib_q;
        live_err_d = live_err_q;
        cap_bits   = 4'b0000;
        if (capture) begin
            live_nib_d[{sel_idx, 2'b00} +: 4] = dec_nib;
            live_err_d[sel_idx]               = dec_err;
            cap_bits                          = sel_sync;
        end
    end

    assign mask_full = ((mask_q | cap_bits) == 4'hF);

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q | cap_bits;
        load_frame  = 1'b0;
        set_overrun = 1'b0;
        ack_take    = 1'b0;
        case (state_q)
            COLLECT: begin
                if (mask_full) begin
                    load_frame = 1'b1;
                    mask_d     = 4'b0000;
                    state_d    = READY;
                end
            end
            READY: begin
                // Ack takes priority; a frame completing on the same edge is simply lost.
                if (frame_ack) begin
                    ack_take = 1'b1;
                    mask_d   = 4'b0000;
                    state_d  = COLLECT;
                end else if (mask_full) begin
                    set_overrun = 1'b1;
                    mask_d      = 4'b0000;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= COLLECT;
            mask_q      <= '0;
            live_nib_q  <= '0;
            live_err_q  <= '0;
            frame_out   <= '0;
            frame_err   <= '0;
            frame_ready <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            live_nib_q <= live_nib_d;
            live_err_q <= live_err_d;
            if (load_frame) begin
                frame_out   <= live_nib_d;
                frame_err   <= live_err_d;
                frame_ready <= 1'b1;
            end else if (ack_take) begin
                frame_ready <= 1'b0;
            end
            if (ack_take) begin
                overrun <= 1'b0;
            end else if (set_overrun) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed bench for seg7_capture_decoder: frames, illegal glyphs, short/multi-hot holds, overrun, glitch, reset.
module tb_seg7_capture_decoder;

    logic        clk;
    logic        reset_n;
    logic [6:0]  segments_in;
    logic [3:0]  digit_sel_in;
    logic        invert;
    logic [15:0] frame_out;
    logic [3:0]  frame_err;
    logic        frame_ready;
    logic        frame_ack;
    logic        overrun;

    int pass_cnt;
    int total_cnt;

    // Lit patterns, bit 6 = middle ... bit 0 = top.
    localparam logic [6:0] P0 = 7'b0111111;
    localparam logic [6:0] P1 = 7'b0000110;
    localparam logic [6:0] P2 = 7'b1011011;
    localparam logic [6:0] P3 = 7'b1001111;
    localparam logic [6:0] P4 = 7'b1100110;
    localparam logic [6:0] P7 = 7'b0000111;
    localparam logic [6:0] P8 = 7'b1111111;
    localparam logic [6:0] P9 = 7'b1101111;
    localparam logic [6:0] PC = 7'b0111001;
    localparam logic [6:0] PD = 7'b1011110;
    localparam logic [6:0] PE = 7'b1111001;
    localparam logic [6:0] PBAD = 7'b0000001;

    seg7_capture_decoder #(.STABLE_CYCLES(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .segments_in  (segments_in),
        .digit_sel_in (digit_sel_in),
        .invert       (invert),
        .frame_out    (frame_out),
        .frame_err    (frame_err),
        .frame_ready  (frame_ready),
        .frame_ack    (frame_ack),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_cnt++;
        if (observed === expected) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive pins at a falling edge and keep them for n rising edges.
    task automatic hold(input logic [3:0] sel, input logic [6:0] seg, input int n);
        @(negedge clk);
        digit_sel_in = sel;
        segments_in  = seg;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
    endtask

    initial begin
        pass_cnt     = 0;
        total_cnt    = 0;
        reset_n      = 1'b0;
        segments_in  = '0;
        digit_sel_in = '0;
        invert       = 1'b0;
        frame_ack    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_frame_out", 32'(frame_out), 32'h0000);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_ready", 32'(frame_ready), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        reset_n = 1'b1;

        // Common-anode frame 4321.
        invert = 1'b1;
        hold(4'b0001, ~P1, 10);
        hold(4'b0010, ~P2, 10);
        hold(4'b0100, ~P3, 10);
        check("inv_partial_ready", 32'(frame_ready), 32'h0);
        hold(4'b1000, ~P4, 10);
        @(negedge clk);
        check("inv_ready", 32'(frame_ready), 32'h1);
        check("inv_frame_out", 32'(frame_out), 32'h4321);
        check("inv_frame_err", 32'(frame_err), 32'h0);
        ack_pulse();
        check("inv_ack_ready", 32'(frame_ready), 32'h0);

        // Illegal glyph on digit 2, short hold and multi-hot on digit 0 first.
        invert = 1'b0;
        hold(4'b0010, P8, 10);
        hold(4'b0100, PBAD, 10);
        hold(4'b1000, P8, 10);
        hold(4'b0001, P8, 3);
        hold(4'b0000, P8, 10);
        check("short_hold_ready", 32'(frame_ready), 32'h0);
        hold(4'b0101, P8, 10);
        check("multihot_ready", 32'(frame_ready), 32'h0);
        hold(4'b0001, P8, 10);
        @(negedge clk);
        check("bad_ready", 32'(frame_ready), 32'h1);
        check("bad_frame_out", 32'(frame_out), 32'h8088);
        check("bad_frame_err", 32'(frame_err), 32'h4);

        // Second full frame without ack.
        hold(4'b0001, P1, 10);
        hold(4'b0010, P2, 10);
        hold(4'b0100, P3, 10);
        hold(4'b1000, P4, 10);
        @(negedge clk);
        check("ovr_overrun", 32'(overrun), 32'h1);
        check("ovr_ready", 32'(frame_ready), 32'h1);
        check("ovr_frame_out", 32'(frame_out), 32'h8088);
        check("ovr_frame_err", 32'(frame_err), 32'h4);
        ack_pulse();
        check("ovr_ack_ready", 32'(frame_ready), 32'h0);
        check("ovr_ack_overrun", 32'(overrun), 32'h0);
        check("ovr_ack_frame_out", 32'(frame_out), 32'h8088);

        // Glitch: digit 0 shows 7 briefly, then settles on 9.
        hold(4'b0001, P7, 3);
        hold(4'b0001, P9, 10);
        hold(4'b0010, PC, 10);
        hold(4'b0100, PD, 10);
        hold(4'b1000, PE, 10);
        @(negedge clk);
        check("glitch_ready", 32'(frame_ready), 32'h1);
        check("glitch_frame_out", 32'(frame_out), 32'hEDC9);
        check("glitch_frame_err", 32'(frame_err), 32'h0);

        // One-cycle reset while READY, digit 3 still on the pins.
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("rst2_frame_out", 32'(frame_out), 32'h0000);
        check("rst2_frame_err", 32'(frame_err), 32'h0);
        check("rst2_ready", 32'(frame_ready), 32'h0);
        check("rst2_overrun", 32'(overrun), 32'h0);
        hold(4'b1000, PE, 10);
        hold(4'b0010, P1, 10);
        hold(4'b0100, P2, 10);
        check("rst2_partial_ready", 32'(frame_ready), 32'h0);
        hold(4'b0001, P0, 10);
        @(negedge clk);
        check("rst2_ready_after", 32'(frame_ready), 32'h1);
        check("rst2_frame_out_after", 32'(frame_out), 32'hE210);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
